// File: rtl/ram1_pkg.sv
// Shared constants and types for the ram1 scratch memory.
// Default geometry, sweep state encoding and read-data source select.
package ram1_pkg;

    localparam int DEF_ADDR_SIZE   = 10;
    localparam int DEF_WORD_SIZE   = 8;
    localparam int DEF_MEMORY_SIZE = 1024;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Which registered source currently drives data_out.
    typedef enum logic [1:0] {
        OUT_ZERO = 2'd0,
        OUT_MEM  = 2'd1,
        OUT_WT   = 2'd2
    } out_sel_t;

endpackage

// File: rtl/ram1_array.sv
// Bare synchronous single-port storage with read-first registered output.
// Infers as block RAM; rdata updates only on enabled cycles.
module ram1_array #(
    parameter int ADDR_SIZE   = 10,
    parameter int WORD_SIZE   = 8,
    parameter int MEMORY_SIZE = 1024
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

    // NOTE: the array has no reset; a reset port would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram1.sv
// Single-port synchronous RAM with chip select, write-through and a
// post-reset clearing sweep that zeroes every word before accesses are accepted.
module ram1
    import ram1_pkg::*;
#(
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [WORD_SIZE-1:0] data_out,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic                 wr,
    input  logic                 cs,
    output logic                 ready
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);

    state_t               state;
    logic [ADDR_SIZE-1:0] init_cnt;
    out_sel_t             out_sel;
    logic [WORD_SIZE-1:0] wt_data;

    logic                 in_range;
    logic                 arr_en;
    logic                 arr_we;
    logic [ADDR_SIZE-1:0] arr_addr;
    logic [WORD_SIZE-1:0] arr_wdata;
    logic [WORD_SIZE-1:0] arr_rdata;

    assign in_range = (int'(addr) < MEMORY_SIZE);

    // Sweep owns the array in INIT; the bus owns it in RUN.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = init_cnt;
        arr_wdata = '0;
        if (state == INIT) begin
            arr_en = 1'b1;
            arr_we = 1'b1;
        end else begin
            arr_en    = cs && in_range;
            arr_we    = wr;
            arr_addr  = addr;
            arr_wdata = data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == LAST_ADDR) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Output source tracking keeps data_out resettable while the array itself is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sel <= OUT_ZERO;
            wt_data <= '0;
        end else if (state == RUN && cs) begin
            if (wr) begin
                out_sel <= OUT_WT;
                wt_data <= data_in;
            end else if (in_range) begin
                out_sel <= OUT_MEM;
            end else begin
                out_sel <= OUT_ZERO;
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (out_sel)
            OUT_MEM:  data_out = arr_rdata;
            OUT_WT:   data_out = wt_data;
            default:  data_out = '0;
        endcase
    end

    ram1_array #(
        .ADDR_SIZE   (ADDR_SIZE),
        .WORD_SIZE   (WORD_SIZE),
        .MEMORY_SIZE (MEMORY_SIZE)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_ram1.sv
// Directed self-checking bench for ram1: init sweep, write-through, read-back,
// deselect, boundary overwrite and asynchronous reset behaviour.
module tb_ram1;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic [9:0] addr;
    logic       wr;
    logic       cs;
    logic       ready;

    int n_checks;
    int n_errors;
    int dout_bad;

    ram1 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_out (data_out),
        .data_in  (data_in),
        .addr     (addr),
        .wr       (wr),
        .cs       (cs),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic c, input logic w, input logic [9:0] a, input logic [7:0] d);
        cs      = c;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    // Count edges until ready rises; data_out must stay 0 throughout.
    task automatic wait_ready(output int n);
        n = 0;
        dout_bad = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            n++;
            if (data_out !== 8'h00) dout_bad++;
            if (ready === 1'b1) break;
        end
    endtask

    int cycles;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus(1'b0, 1'b0, 10'd0, 8'h00);
        #3;
        check("reset_dout", 32'(data_out), 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        step();
        step();
        #3 rst_n = 1'b1;

        // 1. Init sweep with cs held low
        wait_ready(cycles);
        check("init_len", 32'(cycles), 32'd1024);
        check("init_dout_zero", 32'(dout_bad), 32'd0);

        // 2. Write-through on writes, then read-back with one-cycle latency
        for (int k = 0; k <= 16; k++) begin
            bus(1'b1, 1'b1, 10'(k), 8'((2 * k) % 256));
            step();
            check($sformatf("wt_%0d", k), 32'(data_out), 32'((2 * k) % 256));
        end
        for (int k = 0; k <= 16; k++) begin
            bus(1'b1, 1'b0, 10'(k), 8'hFF);
            step();
            check($sformatf("rd_%0d", k), 32'(data_out), 32'((2 * k) % 256));
        end

        // 3. Unwritten locations read as zero
        bus(1'b1, 1'b0, 10'd1023, 8'h00);
        step();
        check("unwritten_1023", 32'(data_out), 32'h0);
        bus(1'b1, 1'b0, 10'd16, 8'h00);
        step();
        bus(1'b1, 1'b0, 10'd500, 8'h00);
        step();
        check("unwritten_500", 32'(data_out), 32'h0);

        // 4. Deselect ignores writes and holds data_out
        bus(1'b1, 1'b1, 10'd5, 8'hAA);
        step();
        check("desel_wt", 32'(data_out), 32'hAA);
        bus(1'b0, 1'b1, 10'd5, 8'h55);
        step();
        check("desel_hold_wr", 32'(data_out), 32'hAA);
        bus(1'b0, 1'b0, 10'd5, 8'h55);
        step();
        bus(1'b1, 1'b0, 10'd5, 8'h00);
        step();
        check("desel_readback", 32'(data_out), 32'hAA);
        bus(1'b0, 1'b0, 10'd0, 8'h00);
        step();
        check("desel_hold_rd", 32'(data_out), 32'hAA);
        bus(1'b0, 1'b1, 10'd0, 8'h33);
        step();
        bus(1'b1, 1'b0, 10'd0, 8'h00);
        step();
        check("desel_addr0_kept", 32'(data_out), 32'h0);

        // 5. Last address, back-to-back overwrite
        bus(1'b1, 1'b1, 10'd1023, 8'h11);
        step();
        bus(1'b1, 1'b1, 10'd1023, 8'h22);
        step();
        bus(1'b1, 1'b0, 10'd1023, 8'h00);
        step();
        check("overwrite_1023", 32'(data_out), 32'h22);

        // 6. Asynchronous reset in RUN, then a reset mid-sweep
        bus(1'b1, 1'b1, 10'd3, 8'h7F);
        step();
        check("pre_reset_wt", 32'(data_out), 32'h7F);
        check("pre_reset_ready", 32'(ready), 32'h1);
        bus(1'b0, 1'b0, 10'd0, 8'h00);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(data_out), 32'h0);
        check("async_rst_ready", 32'(ready), 32'h0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("mid_sweep_ready", 32'(ready), 32'h0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        wait_ready(cycles);
        check("resweep_len", 32'(cycles), 32'd1024);
        check("resweep_dout_zero", 32'(dout_bad), 32'd0);
        bus(1'b1, 1'b0, 10'd3, 8'h00);
        step();
        check("cleared_3", 32'(data_out), 32'h0);
        bus(1'b1, 1'b0, 10'd1023, 8'h00);
        step();
        check("cleared_1023", 32'(data_out), 32'h0);
        bus(1'b1, 1'b0, 10'd5, 8'h00);
        step();
        check("cleared_5", 32'(data_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
